shift_normalizer: RTL
=====================

# shift_normalizer

Iterative left-normalizer for the 16-bit ALU datapath: the inverse operation of the shifting unit. Given an operand, it shifts left one bit per cycle until the value is normalized and reports the result with the shift distance taken. Feeds leading-zero / leading-sign counts and normalized mantissas to downstream multiply/divide and fixed-point scaling logic, under a start/done handshake.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 2.
- CW, $clog2(WIDTH)+1, shift_count width (5 for WIDTH=16); holds 0..WIDTH.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = unsigned (normalize until bit[W-1]=1), 1 = signed (normalize until bit[W-1] != bit[W-2]); captured with start.
- operand  input  WIDTH  value to normalize; captured on the accepting edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result fields valid from this cycle.
- result  output  WIDTH  normalized value.
- shift_count  output  CW  number of left shifts applied.
- zero  output  1  operand was zero; result=0, shift_count=WIDTH.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → working register ← operand, count ← 0, mode latched, go to SHIFT. start=0 → stay.
- SHIFT, one evaluation per cycle:
  - Register is zero → zero ← 1, count ← WIDTH, go to DONE.
  - Register is normalized per latched mode → go to DONE, no shift.
  - Otherwise register ← register << 1 (zero fill), count ← count + 1, stay.
  - Safety bound: count == WIDTH-1 forces DONE. Unreachable for nonzero inputs; it must never fire on a legal input.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Signed rules:
  - 0xFFFF normalizes to 0x8000, count 15.
  - 0x0000 is zero, count 16 (same as unsigned).
  - Negative values shift in zeros until bit15 != bit14.
- start while busy (SHIFT or DONE) is ignored. The request is not queued.
- operand and mode changes after acceptance have no effect.
- result, shift_count, and zero hold their values from DONE until the next accepted start.
- zero clears on acceptance of a new start.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, shift_count=0, zero=0, working register 0.
- rst mid-operation aborts with no done pulse; the reset values above apply on the next cycle.
- start accepted at edge t:
  - busy high from cycle t+1.
  - done high in cycle t+2+k, where k = shift_count (k=0 for zero input).
  - busy low in cycle t+3+k.
- Latency range: 2 cycles (already normalized or zero) to 17 cycles (unsigned 0x0001, k=15).
- Back-to-back: a start in the first IDLE cycle after DONE is accepted. Minimum issue interval is k+3 cycles.

## Structure
- Shared ALU package holds:
  - state enum {IDLE, SHIFT, DONE}.
  - mode constants NORM_UNSIGNED=1'b0, NORM_SIGNED=1'b1.
  - default WIDTH constant, shared with the shifting unit.
- Optional sub-module norm_detect: combinational; inputs value and mode, outputs is_normalized and is_zero. It is reusable by a future single-cycle leading-zero counter.
- Everything else stays in one module: FSM, working register, counter.

## Test plan
- Unsigned 0x0001 → result 0x8000, shift_count 15, zero 0; done exactly 17 cycles after the start edge, single-cycle pulse.
- Unsigned 0x8000, then signed 0x4000 → each gives count 0 with the input value as result; done 2 cycles after start.
- Signed 0xFFFF → 0x8000/15; signed 0xF000 → 0x8000/3; signed 0x0001 → 0x4000/14.
- Zero input, both modes → result 0x0000, shift_count 16, zero 1, done at t+2. A following nonzero start clears zero.
- start pulsed every cycle during a 0x0010 unsigned operation → only the first is accepted; result 0x8000/11. Operand changes mid-run do not alter the result.
- rst asserted during SHIFT of 0x0001 → next cycle all outputs are reset values, no done pulse. A start immediately after reset completes normally.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared ALU definitions: normalizer FSM states, normalization modes and
// the default datapath width used by the shifting and normalizing units.
package shift_normalizer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/shift_normalizer_norm_detect.sv
// Combinational normalization test for one value; kept standalone so a
// single-cycle leading-zero counter can reuse it.
module norm_detect
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             mode,
    output logic             is_normalized,
    output logic             is_zero
);

    assign is_zero = (value == '0);

    // Signed values are normalized once the sign bit differs from the bit below it.
    assign is_normalized = (mode == NORM_UNSIGNED) ? value[WIDTH-1]
                                                   : (value[WIDTH-1] ^ value[WIDTH-2]);

endmodule

// File: rtl/shift_normalizer.sv
// Iterative left-normalizer: shifts one bit per cycle until the operand is
// normalized, reporting the result and the shift distance under start/done.
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    shift_count,
    output logic             zero
);

    localparam logic [CW-1:0] COUNT_ZERO  = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(WIDTH - 1);

    norm_state_t      state, state_next;
    logic [WIDTH-1:0] work, work_next;
    logic [CW-1:0]    count, count_next;
    logic             zero_q, zero_next;
    logic             mode_q, mode_next;
    logic             is_normalized, is_zero;

    norm_detect #(.WIDTH(WIDTH)) u_detect (
        .value         (work),
        .mode          (mode_q),
        .is_normalized (is_normalized),
        .is_zero       (is_zero)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next = state;
        work_next  = work;
        count_next = count;
        zero_next  = zero_q;
        mode_next  = mode_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    work_next  = operand;
                    count_next = '0;
                    zero_next  = 1'b0;
                    mode_next  = mode;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (is_zero) begin
                    zero_next  = 1'b1;
                    count_next = COUNT_ZERO;
                    state_next = DONE;
                end else if (is_normalized || count == COUNT_LIMIT) begin
                    state_next = DONE;
                end else begin
                    work_next  = {work[WIDTH-2:0], 1'b0};
                    count_next = count + CW'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            zero_q <= 1'b0;
            mode_q <= NORM_UNSIGNED;
        end else begin
            state  <= state_next;
            work   <= work_next;
            count  <= count_next;
            zero_q <= zero_next;
            mode_q <= mode_next;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign result      = work;
    assign shift_count = count;
    assign zero        = zero_q;

endmodule
